apb_slave_mem: RTL and testbench



---
 rtl/apb_slave_mem.sv | 149 ++++++++++++++
 tb/tb_apb_slave_mem.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB completer backed by a small word-addressed register bank.
// Each access inserts a programmable number of wait states. Addresses outside the bank complete with PSLVERR.
module apb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  PCLK_i,
  input  logic                  PRESET_i,
  input  logic                  PSEL_i,
  input  logic                  PENABLE_i,
  input  logic                  PWRITE_i,
  input  logic [ADDR_WIDTH-1:0] PADDR_i,
  input  logic [DATA_WIDTH-1:0] PWDATA_i,
  output logic [DATA_WIDTH-1:0] PRDATA_o,
  output logic                  PREADY_o,
  output logic                  PSLVERR_o
);

  localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [7:0]            WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic                    write_reg, write_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0]   prdata_reg, prdata_next;
  logic                    pready_reg, pready_next;
  logic                    pslverr_reg, pslverr_next;

  logic [DATA_WIDTH-1:0]   mem_reg [DEPTH];
  logic [IDX_W-1:0]        mem_idx;
  logic [DATA_WIDTH-1:0]   mem_rd;
  logic                    mem_we;
  logic                    in_range;
  logic                    access_ok;
  logic                    access_edge;

  // Full-width compare so high address bits never alias onto the bank.
  assign in_range    = (addr_reg < DEPTH_A);
  assign mem_idx     = addr_reg[IDX_W-1:0];
  assign mem_rd      = mem_reg[mem_idx];
  assign access_ok   = PSEL_i && PENABLE_i;
  assign access_edge = (state_reg == S_WAIT) && access_ok && (cnt_reg == 8'd0);

  // State and registered-output process.
  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 8'd0;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      write_reg   <= write_next;
      wdata_reg   <= wdata_next;
      prdata_reg  <= prdata_next;
      pready_reg  <= pready_next;
      pslverr_reg <= pslverr_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (access_ok) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!access_ok) begin
          state_next = S_IDLE;
        end else if (cnt_reg == 8'd0) begin
          state_next = S_RESP;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and output next values; outputs default to the idle response.
  always_comb begin
    cnt_next     = cnt_reg;
    addr_next    = addr_reg;
    write_next   = write_reg;
    wdata_next   = wdata_reg;
    prdata_next  = prdata_reg;
    pready_next  = 1'b0;
    pslverr_next = 1'b0;
    mem_we       = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (access_ok) begin
          addr_next  = PADDR_i;
          write_next = PWRITE_i;
          wdata_next = PWDATA_i;
          cnt_next   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (access_edge) begin
          pready_next  = 1'b1;
          pslverr_next = !in_range;
          if (write_reg) begin
            mem_we = in_range;
          end else begin
            prdata_next = in_range ? mem_rd : '0;
          end
        end else if (access_ok) begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (mem_we) begin
      mem_reg[mem_idx] <= wdata_reg;
    end
  end

  assign PRDATA_o  = prdata_reg;
  assign PREADY_o  = pready_reg;
  assign PSLVERR_o = pslverr_reg;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized APB bench for apb_slave_mem with three wait-state builds (1, 0, 4).
// Every response is compared against a word-array model of the bank.
module tb_apb_slave_mem;

  localparam int NDUT  = 3;
  localparam int DEPTH = 32;

  logic        clk;
  logic        srst;
  logic [NDUT-1:0] psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr  [NDUT];
  logic [31:0] pwdata [NDUT];
  logic [31:0] prdata [NDUT];

  int n_checks;
  int n_errors;

  logic [31:0] model_mem [NDUT][DEPTH];
  logic [31:0] exp_prdata [NDUT];

  function automatic int wc(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 4;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      apb_slave_mem #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .WAIT_CYCLES((gi == 0) ? 1 : (gi == 1) ? 0 : 4)
      ) dut (
        .PCLK_i   (clk),
        .PRESET_i (srst),
        .PSEL_i   (psel[gi]),
        .PENABLE_i(penable[gi]),
        .PWRITE_i (pwrite[gi]),
        .PADDR_i  (paddr[gi]),
        .PWDATA_i (pwdata[gi]),
        .PRDATA_o (prdata[gi]),
        .PREADY_o (pready[gi]),
        .PSLVERR_o(pslverr[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < NDUT; d++) begin
      exp_prdata[d] = '0;
      for (int w = 0; w < DEPTH; w++) model_mem[d][w] = '0;
    end
  endtask

  task automatic check_idle_zero(input int d);
    check("rst_pready", {63'd0, pready[d]}, 64'd0);
    check("rst_pslverr", {63'd0, pslverr[d]}, 64'd0);
    check("rst_prdata", {32'd0, prdata[d]}, 64'd0);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    srst = 1'b0;
    model_clear();
    for (int d = 0; d < NDUT; d++) check_idle_zero(d);
    $display("RESET all builds");
  endtask

  // mode: 0 normal, 1 drop PENABLE in first wait cycle, 2 reset during wait,
  // 3 scramble PADDR/PWDATA during wait.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input int mode);
    int  n;
    bit  exp_err;
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    @(posedge clk); #1;
    check("ready_low_after_e0", {63'd0, pready[d]}, 64'd0);

    if (mode == 1) begin
      penable[d] = 1'b0;
      for (int k = 0; k < wc(d) + 3; k++) begin
        @(posedge clk); #1;
        check("abort_no_ready", {63'd0, pready[d]}, 64'd0);
      end
      psel[d] = 1'b0;
      $display("XFER dut=%0d %s addr=%0h data=%0h ABORTED", d, wr ? "WR" : "RD", addr, data);
      return;
    end

    if (mode == 2) begin
      srst = 1'b1;
      @(posedge clk); #1;
      srst = 1'b0;
      psel[d] = 1'b0; penable[d] = 1'b0;
      model_clear();
      check_idle_zero(d);
      $display("XFER dut=%0d %s addr=%0h data=%0h RESET_IN_WAIT", d, wr ? "WR" : "RD", addr, data);
      return;
    end

    if (mode == 3) begin
      paddr[d]  = $urandom();
      pwdata[d] = $urandom();
    end

    n = 0;
    while (pready[d] !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 64) begin
      check("timeout_pready", {63'd0, pready[d]}, 64'd1);
      psel[d] = 1'b0; penable[d] = 1'b0;
      return;
    end

    exp_err = (addr >= DEPTH);
    if (!exp_err) begin
      if (wr) model_mem[d][addr] = data;
      else    exp_prdata[d] = model_mem[d][addr];
    end else if (!wr) begin
      exp_prdata[d] = '0;
    end

    check("latency", 64'(n), 64'(wc(d) + 1));
    check("pslverr", {63'd0, pslverr[d]}, {63'd0, exp_err});
    check("prdata", {32'd0, prdata[d]}, {32'd0, exp_prdata[d]});

    @(posedge clk); #1;
    check("ready_single_pulse", {63'd0, pready[d]}, 64'd0);
    check("pslverr_cleared", {63'd0, pslverr[d]}, 64'd0);
    psel[d] = 1'b0; penable[d] = 1'b0;
    $display("XFER dut=%0d %s addr=%0h data=%0h lat=%0d err=%0b prdata=%0h",
             d, wr ? "WR" : "RD", addr, data, n, pslverr[d], prdata[d]);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    int          d;
    n_checks = 0;
    n_errors = 0;
    srst = 1'b1;
    psel = '0; penable = '0; pwrite = '0;
    for (int i = 0; i < NDUT; i++) begin
      paddr[i] = '0; pwdata[i] = '0;
    end
    model_clear();

    do_reset();
    xfer(0, 1'b0, 32'd5, 32'd0, 0);

    xfer(0, 1'b1, 32'd14, 32'd25, 0);
    xfer(0, 1'b0, 32'd14, 32'd0, 0);

    xfer(0, 1'b1, 32'd12, 32'd20, 0);
    xfer(0, 1'b1, 32'd0,  32'd10, 0);
    xfer(0, 1'b1, 32'd31, 32'd50, 0);
    xfer(0, 1'b0, 32'd31, 32'd0, 0);
    xfer(0, 1'b0, 32'd0,  32'd0, 0);
    xfer(0, 1'b0, 32'd12, 32'd0, 0);

    xfer(0, 1'b1, 32'd32, 32'd99, 0);
    xfer(0, 1'b0, 32'd32, 32'd0, 0);
    xfer(0, 1'b0, 32'd0,  32'd0, 0);

    xfer(0, 1'b1, 32'd3, 32'd77, 1);
    xfer(0, 1'b0, 32'd3, 32'd0, 0);

    xfer(0, 1'b1, 32'd4, 32'h1234, 2);
    xfer(0, 1'b0, 32'd4, 32'd0, 0);

    for (int k = 1; k < NDUT; k++) begin
      xfer(k, 1'b1, 32'd1, 32'd13, 0);
      xfer(k, 1'b0, 32'd1, 32'd0, 0);
    end

    for (int t = 0; t < 200; t++) begin
      d = $urandom_range(0, NDUT - 1);
      if ($urandom_range(0, 9) == 0) a = $urandom() | 32'h0000_0100;
      else                           a = 32'($urandom_range(0, 40));
      r = $urandom_range(0, 99);
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom(),
           (r < 8) ? 1 : (r < 18) ? 3 : (r < 20) ? 2 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
